// File: rtl/wishbone_uart_rx_lite.sv
// Wishbone-slave 8N1 UART receiver with a small receive FIFO and a status register.
module wishbone_uart_rx_lite #(
  parameter int unsigned ClkFreq   = 20000000,
  parameter int unsigned BaudRate  = 115200,
  parameter int unsigned FifoDepth = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o,
  output logic        rx_irq
);

  localparam int unsigned Div    = ClkFreq / BaudRate;
  localparam int unsigned Half   = Div / 2;
  localparam int unsigned CntW   = 16;
  localparam int unsigned AddrW  = $clog2(FifoDepth);
  localparam int unsigned CountW = AddrW + 1;

  localparam logic [CntW-1:0]   DivLast   = CntW'(Div - 1);
  localparam logic [CntW-1:0]   HalfCnt   = CntW'(Half);
  localparam logic [CountW-1:0] FullCount = CountW'(FifoDepth);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {B_IDLE, B_ACK} bus_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t         rx_state, rx_state_nxt;
  logic [CntW-1:0]   cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              stop_ok_c;
  logic              stop_bad_c;

  // Receive state register and bit-timing datapath.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
    end
  end

  // Next-state logic: mid-bit sampling of start, data and stop bits.
  always_comb begin
    rx_state_nxt = rx_state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    stop_ok_c    = 1'b0;
    stop_bad_c   = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        if (!rxs) begin
          rx_state_nxt = R_START;
          cnt_nxt      = '0;
        end
      end
      R_START: begin
        if (cnt == HalfCnt) begin
          cnt_nxt = '0;
          if (!rxs) begin
            rx_state_nxt = R_DATA;
            bit_idx_nxt  = '0;
          end else begin
            rx_state_nxt = R_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      R_DATA: begin
        if (cnt == DivLast) begin
          shift_nxt[bit_idx] = rxs;
          cnt_nxt            = '0;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            rx_state_nxt = R_STOP;
          end
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      R_STOP: begin
        if (cnt == DivLast) begin
          stop_ok_c    = rxs;
          stop_bad_c   = ~rxs;
          cnt_nxt      = '0;
          rx_state_nxt = R_IDLE;
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO and sticky error flags
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [FifoDepth];
  logic [AddrW-1:0]  wr_ptr, rd_ptr;
  logic [CountW-1:0] count;
  logic              overrun, frame_err;
  logic              nonempty_c, full_c;
  logic              push_c, pop_c, ovr_set_c;
  logic              clr_ovr_c, clr_fe_c;

  assign nonempty_c = (count != '0);
  assign full_c     = (count == FullCount);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push_c     = stop_ok_c & (~full_c | pop_c);
  assign ovr_set_c  = stop_ok_c & full_c & ~pop_c;

  // FIFO storage; no reset needed since entries are only read behind count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AddrW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AddrW'(1);
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event beats a software clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun & ~clr_ovr_c) | ovr_set_c;
      frame_err <= (frame_err & ~clr_fe_c) | stop_bad_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone slave
  // ---------------------------------------------------------------------------
  bus_state_t  b_state, b_state_nxt;
  logic        accept_c;
  logic        sel_status_c;
  logic [31:0] rd_data_c;
  logic        unused_c;

  assign sel_status_c = wishbone_addr_i[2];
  assign pop_c        = accept_c & ~wishbone_we_i & ~sel_status_c & nonempty_c;
  assign clr_ovr_c    = accept_c & wishbone_we_i & sel_status_c & wishbone_data_i[1];
  assign clr_fe_c     = accept_c & wishbone_we_i & sel_status_c & wishbone_data_i[2];
  assign unused_c     = ^{wishbone_sel_i, wishbone_addr_i[31:3], wishbone_addr_i[1:0],
                          wishbone_data_i[31:3], wishbone_data_i[0]};

  // Read-data mux: STATUS word or head byte tagged with the valid bit.
  always_comb begin
    rd_data_c = '0;
    if (sel_status_c) begin
      rd_data_c = {28'b0, full_c, frame_err, overrun, nonempty_c};
    end else if (nonempty_c) begin
      rd_data_c = {23'b0, 1'b1, mem[rd_ptr]};
    end
  end

  // Bus state register and registered bus/interrupt outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      b_state         <= B_IDLE;
      wishbone_ack_o  <= 1'b0;
      wishbone_data_o <= '0;
      rx_irq          <= 1'b0;
    end else begin
      b_state        <= b_state_nxt;
      wishbone_ack_o <= accept_c;
      if (accept_c) begin
        wishbone_data_o <= rd_data_c;
      end
      rx_irq <= nonempty_c;
    end
  end

  // Bus next-state: accept one request in B_IDLE, acknowledge it in B_ACK.
  always_comb begin
    b_state_nxt = b_state;
    accept_c    = 1'b0;
    unique case (b_state)
      B_IDLE: begin
        if (wishbone_cyc_i & wishbone_stb_i) begin
          accept_c    = 1'b1;
          b_state_nxt = B_ACK;
        end
      end
      B_ACK:   b_state_nxt = B_IDLE;
      default: b_state_nxt = B_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_uart_rx_lite.sv
// Randomized self-checking bench for wishbone_uart_rx_lite against a queue-based model.
module tb_wishbone_uart_rx_lite;

  localparam int unsigned DIV   = 20000000 / 115200;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_rx;
  logic [31:0] wishbone_addr_i;
  logic [31:0] wishbone_data_i;
  logic        wishbone_we_i;
  logic [3:0]  wishbone_sel_i;
  logic        wishbone_stb_i;
  logic        wishbone_cyc_i;
  logic [31:0] wishbone_data_o;
  logic        wishbone_ack_o;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  bit         m_ovr;
  bit         m_fe;

  wishbone_uart_rx_lite dut (
    .clk             (clk),
    .resetn          (resetn),
    .ser_rx          (ser_rx),
    .wishbone_addr_i (wishbone_addr_i),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_we_i   (wishbone_we_i),
    .wishbone_sel_i  (wishbone_sel_i),
    .wishbone_stb_i  (wishbone_stb_i),
    .wishbone_cyc_i  (wishbone_cyc_i),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_ack_o  (wishbone_ack_o),
    .rx_irq          (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s    = '0;
    s[3] = (model_q.size() == DEPTH);
    s[2] = m_fe;
    s[1] = m_ovr;
    s[0] = (model_q.size() != 0);
    return s;
  endfunction

  task automatic model_clear();
    model_q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  // One bus transfer; waits a bounded number of cycles for ack.
  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    wishbone_cyc_i  = 1'b1;
    wishbone_stb_i  = 1'b1;
    wishbone_we_i   = we;
    wishbone_addr_i = addr;
    wishbone_data_i = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1);
      if (wishbone_ack_o) begin
        got   = 1'b1;
        rdata = wishbone_data_o;
      end
    end
    wishbone_cyc_i = 1'b0;
    wishbone_stb_i = 1'b0;
    wishbone_we_i  = 1'b0;
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] r;
    logic [31:0] exp;
    wb_xfer(1'b0, 32'h0, 32'h0, r);
    if (model_q.size() != 0) exp = 32'h100 | 32'(model_q.pop_front());
    else exp = 32'h0;
    check_eq(tag, r, exp);
  endtask

  task automatic read_status_check(input string tag);
    logic [31:0] r;
    wb_xfer(1'b0, 32'h4, 32'h0, r);
    check_eq(tag, r, exp_status());
  endtask

  task automatic write_status(input logic [31:0] v);
    logic [31:0] r;
    wb_xfer(1'b1, 32'h4, v, r);
    if (v[1]) m_ovr = 1'b0;
    if (v[2]) m_fe  = 1'b0;
  endtask

  // Serialize one 8N1 frame; a bad frame holds the stop bit low past its sample point.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    ser_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      tick(DIV);
    end
    if (stop_ok) begin
      ser_rx = 1'b1;
      tick(2 * DIV);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      ser_rx = 1'b0;
      tick(110);
      ser_rx = 1'b1;
      tick(2 * DIV);
      m_fe = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    bit          ok;
    int          n;
    resetn          = 1'b0;
    ser_rx          = 1'b1;
    wishbone_addr_i = '0;
    wishbone_data_i = '0;
    wishbone_we_i   = 1'b0;
    wishbone_sel_i  = 4'hF;
    wishbone_stb_i  = 1'b0;
    wishbone_cyc_i  = 1'b0;
    model_clear();
    tick(3);
    check_eq("rst_ack", 32'(wishbone_ack_o), 32'd0);
    check_eq("rst_data", wishbone_data_o, 32'd0);
    check_eq("rst_irq", 32'(rx_irq), 32'd0);
    resetn = 1'b1;
    tick(2);
    read_status_check("rst_status");

    // Single byte, poll, read, irq behaviour
    send_frame(8'hA5, 1'b1);
    check_eq("a5_irq", 32'(rx_irq), 32'd1);
    read_status_check("a5_status");
    read_data_check("a5_data");
    check_eq("a5_irq_hold", 32'(rx_irq), 32'd1);
    tick(1);
    check_eq("a5_irq_fall", 32'(rx_irq), 32'd0);
    read_status_check("a5_status_empty");

    // Short low glitch is not a start bit
    ser_rx = 1'b0;
    tick(40);
    ser_rx = 1'b1;
    tick(2 * DIV);
    read_status_check("glitch_status");

    // Framing error and its software clear
    send_frame(8'h3C, 1'b0);
    read_status_check("fe_status");
    check_eq("fe_irq", 32'(rx_irq), 32'd0);
    write_status(32'h4);
    read_status_check("fe_cleared");

    // Overrun on the fifth unread byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    read_status_check("ovr_status");
    for (int i = 0; i < 4; i++) read_data_check("ovr_data");
    read_data_check("ovr_empty_read");
    read_status_check("ovr_after_drain");
    write_status(32'h2);
    read_status_check("ovr_cleared");

    // Reset in the middle of a data bit
    b = 8'h55;
    ser_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 3; i++) begin
      ser_rx = b[i];
      tick(DIV);
    end
    ser_rx = b[3];
    tick(DIV / 2);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    ser_rx = 1'b1;
    model_clear();
    check_eq("midrst_ack", 32'(wishbone_ack_o), 32'd0);
    tick(2 * DIV);
    check_eq("midrst_irq", 32'(rx_irq), 32'd0);
    read_status_check("midrst_status");
    send_frame(8'h7E, 1'b1);
    read_data_check("midrst_7e");

    // Back-to-back reads with strobe held high
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wishbone_cyc_i  = 1'b1;
    wishbone_stb_i  = 1'b1;
    wishbone_we_i   = 1'b0;
    wishbone_addr_i = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_eq("b2b_ack", 32'(wishbone_ack_o), 32'(i % 2));
      if ((i % 2) == 1) begin
        if (model_q.size() != 0) check_eq("b2b_data", wishbone_data_o, 32'h100 | 32'(model_q.pop_front()));
        else check_eq("b2b_empty", wishbone_data_o, 32'h0);
      end
    end
    wishbone_cyc_i = 1'b0;
    wishbone_stb_i = 1'b0;
    tick(2);
    read_status_check("b2b_status");

    // Randomized frames, reads and clears
    for (int it = 0; it < 10; it++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) read_status_check("rnd_status");
        else read_data_check("rnd_data");
      end
      if ($urandom_range(0, 3) == 0) begin
        write_status(32'($urandom_range(0, 3)) << 1);
        read_status_check("rnd_clear");
      end
    end
    while (model_q.size() != 0) read_data_check("drain_data");
    read_data_check("drain_empty");
    read_status_check("drain_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
